// File: rtl/img_mem_arbiter_pkg.sv
// Shared types and constants for the image-memory arbiter and its clients.
package img_mem_pkg;
    localparam int IMG_AW = 15;
    localparam int IMG_DW = 16;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;
endpackage

// File: rtl/img_mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals around the arbiter.
interface img_mem_arbiter_if
    import img_mem_pkg::*;
#(
    parameter int AW = IMG_AW,
    parameter int DW = IMG_DW
) ();
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_gnt, vga_rvalid, vga_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
               mem_we, mem_re, mem_addr, mem_wdata
    );

    // Requesters plus memory, as seen from outside the arbiter
    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
               mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/img_mem_arbiter_tagpipe.sv
// Two-stage owner tag pipeline: follows each read from issue to data return
// and steers the valid strobe back to whichever port issued it.
module img_arb_tagpipe
    import img_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_issRd,
    input  owner_e i_issOwner,
    output logic   o_vgaRvalid,
    output logic   o_cpuRvalid
);
    logic   r_issRd;
    owner_e r_issOwner;
    logic   r_retVld;
    owner_e r_retOwner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issRd    <= 1'b0;
            r_issOwner <= OWN_VGA;
            r_retVld   <= 1'b0;
            r_retOwner <= OWN_VGA;
        end else begin
            r_issRd    <= i_issRd;
            r_issOwner <= i_issOwner;
            r_retVld   <= r_issRd;
            r_retOwner <= r_issOwner;
        end
    end

    // Masked while reset is held so an in-flight return cannot leak out
    assign o_vgaRvalid = !rst && r_retVld && (r_retOwner == OWN_VGA);
    assign o_cpuRvalid = !rst && r_retVld && (r_retOwner == OWN_CPU);
endmodule

// File: rtl/img_mem_arbiter.sv
// Shares the single-port image memory between the VGA fetch port (priority)
// and the CPU load/store port, with a wait counter bounding CPU starvation.
module img_mem_arbiter
    import img_mem_pkg::*;
#(
    parameter int AW       = IMG_AW,
    parameter int DW       = IMG_DW,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    img_mem_arbiter_if.slave  bus
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0]    r_waitCnt;
    logic          w_force;
    logic          w_vgaGnt;
    logic          w_cpuGnt;
    logic          w_issRd;
    owner_e        w_issOwner;
    logic [AW-1:0] w_issAddr;
    logic [DW-1:0] w_rdata;
    logic          w_vgaRvalid;
    logic          w_cpuRvalid;

    always_comb begin
        w_force    = bus.cpu_req && (r_waitCnt == MAX_W);
        w_cpuGnt   = !rst && bus.cpu_req && (w_force || !bus.vga_req);
        w_vgaGnt   = !rst && bus.vga_req && !w_force;
        w_issRd    = w_vgaGnt || (w_cpuGnt && !bus.cpu_we);
        w_issOwner = w_cpuGnt ? OWN_CPU : OWN_VGA;
        w_issAddr  = w_cpuGnt ? bus.cpu_addr : bus.vga_addr;
    end

    assign bus.vga_gnt = w_vgaGnt;
    assign bus.cpu_ack = w_cpuGnt;

    // Counts consecutive denied CPU cycles; any gap in the request restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt <= 8'd0;
        end else if (!bus.cpu_req || w_cpuGnt) begin
            r_waitCnt <= 8'd0;
        end else if (r_waitCnt != MAX_W) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= w_cpuGnt && bus.cpu_we;
            bus.mem_re <= w_issRd;
            if (w_vgaGnt || w_cpuGnt) begin
                bus.mem_addr <= w_issAddr;
            end
            if (w_cpuGnt && bus.cpu_we) begin
                bus.mem_wdata <= bus.cpu_wdata;
            end
        end
    end

    img_arb_tagpipe u_tagpipe (
        .clk         (clk),
        .rst         (rst),
        .i_issRd     (w_issRd),
        .i_issOwner  (w_issOwner),
        .o_vgaRvalid (w_vgaRvalid),
        .o_cpuRvalid (w_cpuRvalid)
    );

    // Read data is shared; each consumer qualifies it with its own rvalid
    assign w_rdata        = bus.mem_rdata;
    assign bus.vga_rdata  = w_rdata;
    assign bus.cpu_rdata  = w_rdata;
    assign bus.vga_rvalid = w_vgaRvalid;
    assign bus.cpu_rvalid = w_cpuRvalid;
endmodule

// File: tb/tb_img_mem_arbiter.sv
// Self-checking bench for img_mem_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_img_mem_arbiter;
    import img_mem_pkg::*;

    localparam int AW       = 15;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 8;
    localparam int DEPTH    = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    img_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    img_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] memArr   [0:DEPTH-1];
    logic          memValid [0:DEPTH-1];
    logic [DW-1:0] refMem   [0:DEPTH-1];

    typedef struct {
        int            due;
        owner_e        owner;
        logic [DW-1:0] data;
    } exp_t;

    function automatic logic [DW-1:0] pat(int a);
        return 16'(a * 7 + 16'h1F00);
    endfunction

    // Synchronous-read memory: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_we) begin
            memArr[bus.mem_addr]   <= bus.mem_wdata;
            memValid[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_re) begin
            bus.mem_rdata <= (memValid[bus.mem_addr] === 1'b1) ? memArr[bus.mem_addr] : pat(int'(bus.mem_addr));
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic idle(int n);
        idleInputs();
        repeat (n) nextCycle();
    endtask

    // Requests during reset must be ignored and all strobes held low
    task automatic test_reset();
        rst = 1'b1;
        bus.vga_req  = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++; if (bus.vga_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vga_gnt: got %b exp 0", bus.vga_gnt); end
            vectors++; if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cpu_ack: got %b exp 0", bus.cpu_ack); end
            vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b exp 0", bus.mem_we); end
            vectors++; if (bus.mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_re: got %b exp 0", bus.mem_re); end
            vectors++; if (bus.mem_addr !== 15'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h exp 0", bus.mem_addr); end
            vectors++; if (bus.mem_wdata !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %h exp 0", bus.mem_wdata); end
            vectors++; if (bus.vga_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b%b exp 00", bus.vga_rvalid, bus.cpu_rvalid); end
            nextCycle();
        end
        idleInputs();
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_strobes: got re=%b we=%b exp 0", bus.mem_re, bus.mem_we); end
            vectors++; if (bus.vga_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_rvalid: got %b%b exp 00", bus.vga_rvalid, bus.cpu_rvalid); end
            nextCycle();
        end
    endtask

    task automatic test_cpu_rw();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0010; bus.cpu_wdata = 16'h1234;
        @(negedge clk);
        vectors++; if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL cpu_write_ack: got %b exp 1", bus.cpu_ack); end
        vectors++; if (bus.vga_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL cpu_write_vga_gnt: got %b exp 0", bus.vga_gnt); end
        refMem[16'h0010] = 16'h1234;
        nextCycle();
        bus.cpu_we = 1'b0;
        @(negedge clk);
        vectors++; if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL cpu_read_ack: got %b exp 1", bus.cpu_ack); end
        vectors++; if (bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL cpu_write_no_rvalid: got %b exp 0", bus.cpu_rvalid); end
        nextCycle();
        idleInputs();
        @(negedge clk);
        vectors++; if (bus.cpu_rvalid !== 1'b0 || bus.vga_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL cpu_read_early: got %b%b exp 00", bus.cpu_rvalid, bus.vga_rvalid); end
        nextCycle();
        @(negedge clk);
        vectors++; if (bus.cpu_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL cpu_read_rvalid: got %b exp 1", bus.cpu_rvalid); end
        vectors++; if (bus.cpu_rdata !== 16'h1234) begin miscompares++; $display("[TB] FAIL cpu_read_data: got %h exp 1234", bus.cpu_rdata); end
        vectors++; if (bus.vga_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL cpu_read_vga_rvalid: got %b exp 0", bus.vga_rvalid); end
        nextCycle();
        idle(2);
    endtask

    task automatic test_vga_stream();
        int addr = 0;
        for (int k = 0; k < 11; k++) begin
            bus.vga_req  = (addr < 8);
            bus.vga_addr = 15'(addr);
            @(negedge clk);
            vectors++; if (bus.vga_gnt !== (k < 8)) begin miscompares++; $display("[TB] FAIL stream_gnt[%0d]: got %b exp %b", k, bus.vga_gnt, (k < 8)); end
            vectors++; if (bus.vga_rvalid !== (k >= 2 && k < 10)) begin miscompares++; $display("[TB] FAIL stream_rvalid[%0d]: got %b exp %b", k, bus.vga_rvalid, (k >= 2 && k < 10)); end
            if (k >= 2 && k < 10) begin
                vectors++; if (bus.vga_rdata !== refMem[k-2]) begin miscompares++; $display("[TB] FAIL stream_data[%0d]: got %h exp %h", k, bus.vga_rdata, refMem[k-2]); end
            end
            vectors++; if (bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_cpu_rvalid[%0d]: got %b exp 0", k, bus.cpu_rvalid); end
            if (bus.vga_gnt === 1'b1) addr++;
            nextCycle();
        end
        idle(2);
    endtask

    // CPU forced in once every MAX_WAIT+1 cycles under continuous VGA load
    task automatic test_contention();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0030;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0020;
        for (int c = 0; c < 19; c++) begin
            logic expAck;
            expAck = (c == MAX_WAIT) || (c == 2 * MAX_WAIT + 1);
            @(negedge clk);
            vectors++; if (bus.cpu_ack !== expAck) begin miscompares++; $display("[TB] FAIL contend_ack[%0d]: got %b exp %b", c, bus.cpu_ack, expAck); end
            vectors++; if (bus.vga_gnt !== !expAck) begin miscompares++; $display("[TB] FAIL contend_gnt[%0d]: got %b exp %b", c, bus.vga_gnt, !expAck); end
            vectors++; if (bus.cpu_rvalid !== (c == MAX_WAIT + 2)) begin miscompares++; $display("[TB] FAIL contend_cpu_rvalid[%0d]: got %b exp %b", c, bus.cpu_rvalid, (c == MAX_WAIT + 2)); end
            if (c == MAX_WAIT + 2) begin
                vectors++; if (bus.cpu_rdata !== refMem[16'h0020]) begin miscompares++; $display("[TB] FAIL contend_cpu_data: got %h exp %h", bus.cpu_rdata, refMem[16'h0020]); end
            end
            nextCycle();
        end
        idle(3);
    endtask

    task automatic test_simultaneous();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0005;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0040;
        @(negedge clk);
        vectors++; if (bus.vga_gnt !== 1'b1 || bus.cpu_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_first: got gnt=%b ack=%b exp 1/0", bus.vga_gnt, bus.cpu_ack); end
        nextCycle();
        bus.vga_req = 1'b0;
        @(negedge clk);
        vectors++; if (dut.r_waitCnt !== 8'd1) begin miscompares++; $display("[TB] FAIL simul_wait1: got %0d exp 1", dut.r_waitCnt); end
        vectors++; if (bus.cpu_ack !== 1'b1 || bus.vga_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_second: got ack=%b gnt=%b exp 1/0", bus.cpu_ack, bus.vga_gnt); end
        nextCycle();
        idleInputs();
        @(negedge clk);
        vectors++; if (dut.r_waitCnt !== 8'd0) begin miscompares++; $display("[TB] FAIL simul_wait0: got %0d exp 0", dut.r_waitCnt); end
        vectors++; if (bus.vga_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_vga_ret: got v=%b c=%b exp 1/0", bus.vga_rvalid, bus.cpu_rvalid); end
        vectors++; if (bus.vga_rdata !== refMem[5]) begin miscompares++; $display("[TB] FAIL simul_vga_data: got %h exp %h", bus.vga_rdata, refMem[5]); end
        nextCycle();
        @(negedge clk);
        vectors++; if (bus.cpu_rvalid !== 1'b1 || bus.vga_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_cpu_ret: got c=%b v=%b exp 1/0", bus.cpu_rvalid, bus.vga_rvalid); end
        vectors++; if (bus.cpu_rdata !== refMem[16'h0040]) begin miscompares++; $display("[TB] FAIL simul_cpu_data: got %h exp %h", bus.cpu_rdata, refMem[16'h0040]); end
        nextCycle();
        idle(2);
    endtask

    task automatic test_reset_midflight();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0001;
        @(negedge clk);
        vectors++; if (bus.vga_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_gnt0: got %b exp 1", bus.vga_gnt); end
        nextCycle();
        bus.vga_addr = 15'h0002;
        @(negedge clk);
        vectors++; if (bus.vga_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_gnt1: got %b exp 1", bus.vga_gnt); end
        nextCycle();
        idleInputs();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++; if (bus.vga_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rvalid_in_rst: got %b exp 0", bus.vga_rvalid); end
            nextCycle();
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++; if (bus.vga_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rvalid_after: got %b%b exp 00", bus.vga_rvalid, bus.cpu_rvalid); end
            vectors++; if (bus.mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_mem_re: got %b exp 0", bus.mem_re); end
            nextCycle();
        end
    endtask

    task automatic test_raw_top();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h7FFF; bus.cpu_wdata = 16'hBEEF;
        @(negedge clk);
        vectors++; if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL raw_write_ack: got %b exp 1", bus.cpu_ack); end
        refMem[15'h7FFF] = 16'hBEEF;
        nextCycle();
        idleInputs();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h7FFF;
        @(negedge clk);
        vectors++; if (bus.vga_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL raw_read_gnt: got %b exp 1", bus.vga_gnt); end
        vectors++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'h7FFF || bus.mem_wdata !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL raw_write_issue: got we=%b a=%h d=%h exp 1/7fff/beef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        nextCycle();
        idleInputs();
        @(negedge clk);
        vectors++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 15'h7FFF) begin miscompares++; $display("[TB] FAIL raw_read_issue: got re=%b a=%h exp 1/7fff", bus.mem_re, bus.mem_addr); end
        nextCycle();
        @(negedge clk);
        vectors++; if (bus.vga_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL raw_rvalid: got %b exp 1", bus.vga_rvalid); end
        vectors++; if (bus.vga_rdata !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL raw_data: got %h exp beef", bus.vga_rdata); end
        nextCycle();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0000;
        nextCycle();
        idleInputs();
        nextCycle();
        @(negedge clk);
        vectors++; if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== refMem[0]) begin miscompares++; $display("[TB] FAIL raw_no_wrap: got v=%b d=%h exp 1/%h", bus.vga_rvalid, bus.vga_rdata, refMem[0]); end
        nextCycle();
        idle(2);
    endtask

    // Random traffic scored against arbitration rules and an in-order read queue
    task automatic test_random();
        exp_t q[$];
        int   streak = 0;
        logic vHold  = 1'b0;
        logic cHold  = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic forced, expCpu, expVga, expV, expC;
            logic [DW-1:0] expD;
            if (!vHold) begin
                bus.vga_req  = ($urandom_range(0, 9) < 6);
                bus.vga_addr = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 15)) : 15'($urandom);
            end
            if (!cHold) begin
                bus.cpu_req   = ($urandom_range(0, 9) < 5);
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = ($urandom_range(0, 3) != 0) ? 15'($urandom_range(0, 15)) : 15'($urandom);
                bus.cpu_wdata = 16'($urandom);
            end
            @(negedge clk);
            forced = bus.cpu_req && (streak == MAX_WAIT);
            expCpu = bus.cpu_req && (forced || !bus.vga_req);
            expVga = bus.vga_req && !forced;
            vectors++; if (bus.cpu_ack !== expCpu) begin miscompares++; $display("[TB] FAIL rand_ack[%0d]: got %b exp %b", cyc, bus.cpu_ack, expCpu); end
            vectors++; if (bus.vga_gnt !== expVga) begin miscompares++; $display("[TB] FAIL rand_gnt[%0d]: got %b exp %b", cyc, bus.vga_gnt, expVga); end
            expV = 1'b0; expC = 1'b0; expD = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e    = q.pop_front();
                expV = (e.owner == OWN_VGA);
                expC = (e.owner == OWN_CPU);
                expD = e.data;
            end
            vectors++; if (bus.vga_rvalid !== expV || bus.cpu_rvalid !== expC) begin miscompares++; $display("[TB] FAIL rand_rvalid[%0d]: got v=%b c=%b exp v=%b c=%b", cyc, bus.vga_rvalid, bus.cpu_rvalid, expV, expC); end
            if (expV) begin
                vectors++; if (bus.vga_rdata !== expD) begin miscompares++; $display("[TB] FAIL rand_vga_data[%0d]: got %h exp %h", cyc, bus.vga_rdata, expD); end
            end
            if (expC) begin
                vectors++; if (bus.cpu_rdata !== expD) begin miscompares++; $display("[TB] FAIL rand_cpu_data[%0d]: got %h exp %h", cyc, bus.cpu_rdata, expD); end
            end
            if (expVga) q.push_back('{due: cyc + 2, owner: OWN_VGA, data: refMem[bus.vga_addr]});
            if (expCpu) begin
                if (bus.cpu_we) refMem[bus.cpu_addr] = bus.cpu_wdata;
                else q.push_back('{due: cyc + 2, owner: OWN_CPU, data: refMem[bus.cpu_addr]});
            end
            if (bus.cpu_req && !expCpu) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
            else streak = 0;
            vHold = bus.vga_req && !expVga;
            cHold = bus.cpu_req && !expCpu && ($urandom_range(0, 19) != 0);
            nextCycle();
        end
        idle(3);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) refMem[a] = pat(a);
        rst = 1'b1;
        idleInputs();
        test_reset();
        test_cpu_rw();
        test_vga_stream();
        test_contention();
        test_simultaneous();
        test_reset_midflight();
        test_raw_top();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/img_mem_arbiter.md
# img_mem_arbiter

Time-shares the single-port image memory (32K × 16, synchronous read) between the VGA painter's fetch port and the processor's load/store port. It replaces the static selector on the memory's address and data inputs. Both requesters can run concurrently. The VGA port has priority, and a wait counter bounds processor starvation. Read data returns to the requester that issued the read, tagged through a two-stage issue/return pipeline.

## Interface
Parameters:
- AW, 15, memory word-address width
- DW, 16, memory data width
- MAX_WAIT, 8, consecutive denied processor cycles before the processor is forced a slot (1..255)

Ports:
- clk  in  1  single clock; every register is posedge clk
- rst  in  1  synchronous, active-high reset
- vga_req  in  1  painter read request
- vga_addr  in  AW  painter read address
- vga_gnt  out  1  painter request accepted this cycle (combinational)
- vga_rvalid  out  1  painter read data valid
- vga_rdata  out  DW  painter read data
- cpu_req  in  1  processor request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  processor address
- cpu_wdata  in  DW  processor write data
- cpu_ack  out  1  processor request accepted this cycle (combinational)
- cpu_rvalid  out  1  processor read data valid
- cpu_rdata  out  DW  processor read data
- mem_we, mem_re  out  1  registered memory strobes
- mem_addr  out  AW  registered memory address
- mem_wdata  out  DW  registered memory write data
- mem_rdata  in  DW  memory read data, one cycle after the strobe

## Operation
- At most one grant per cycle. vga_gnt and cpu_ack are never both high.
- Arbitration in cycle N:
  - cpu_req & wait_cnt==MAX_WAIT: grant the CPU, even if vga_req is high.
  - Otherwise, vga_req: grant the VGA.
  - Otherwise, cpu_req: grant the CPU.
- wait_cnt (8 bit):
  - cleared when cpu_req is low or the CPU is granted.
  - incremented when cpu_req is high and the CPU is denied.
  - saturates at MAX_WAIT.
- Issue stage registers at the end of cycle N: mem_addr, mem_wdata, mem_we (CPU write), mem_re (any read), iss_owner, iss_rd.
- Return stage registers at the end of cycle N+1: ret_vld = iss_rd, and ret_owner.
- In cycle N+2: vga_rvalid = ret_vld & owner==VGA, and cpu_rvalid = ret_vld & owner==CPU.
- vga_rdata and cpu_rdata both pass mem_rdata through combinationally. The consumer must qualify them with its rvalid.
- A CPU write is complete at cpu_ack and produces no rvalid.
- A denied requester must hold its request and payload stable. The arbiter does not latch a denied request.
- No state machine beyond the wait counter and the two tag stages.

## Timing
- Read latency is fixed at 2 cycles from grant to rvalid for both ports. Throughput is 1 access per cycle.
- Back-to-back grants pipeline: the return for grant N coincides with the issue for N+1.
- Reset values: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, iss/ret valid=0, wait_cnt=0. Therefore vga_gnt, cpu_ack, vga_rvalid and cpu_rvalid are all 0 during and after rst until a new grant.
- Reset mid-operation: in-flight reads are dropped. No rvalid appears in the two cycles after rst deasserts unless new grants are made.
- Simultaneous requests with wait_cnt<MAX_WAIT: the VGA wins and wait_cnt increments.
- With continuous vga_req, the CPU is granted exactly once every MAX_WAIT+1 cycles. The VGA loses that cycle and holds its request.
- cpu_req dropping before ack is legal: wait_cnt clears and nothing is issued.
- Read-after-write to the same address is in order. The memory sees the write before the later read.

## Structure
- Package img_mem_pkg holds:
  - owner_e enum {OWN_VGA, OWN_CPU}
  - the IMG_AW=15 and IMG_DW=16 constants, shared with the top and the painter.
- One sub-module, img_arb_tagpipe: the issue/return owner pipeline with rvalid decode. Arbitration and the wait counter stay in the parent.

## Test plan
- CPU only: write 0x1234 to 0x0010, then read 0x0010. Required: cpu_ack in both request cycles, then cpu_rvalid 2 cycles after the read ack with cpu_rdata=0x1234, and no vga_rvalid.
- VGA streaming with vga_req held high, addresses 0..7 advancing on each gnt: vga_rvalid on 8 consecutive cycles starting 2 cycles after the first gnt, with data in address order.
- Contention with MAX_WAIT=8: vga_req continuously high, cpu_req high from cycle 0. Required: cpu_ack exactly at cycle 8, vga_gnt low only in cycle 8, and the next forced CPU grant at cycle 17 if cpu_req is re-asserted immediately.
- Simultaneous first requests: VGA granted and wait_cnt=1. VGA deasserts next cycle and the CPU is granted with wait_cnt back to 0.
- Reset mid-flight: grant two VGA reads, assert rst in the cycle after the second grant. Required: no vga_rvalid while rst is high or for 2 cycles after it falls, and mem_re=0 after reset.
- Interleaved read-after-write: CPU write 0xBEEF to 0x7FFF (top address), then VGA read of 0x7FFF. Required: vga_rdata=0xBEEF with vga_rvalid, and address wrap-free at the width boundary.
